// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen register access path.
// Holds the access FSM state encoding and the byte-strobe expansion helper.
package rggen_rtl_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPONSE
  } access_state_e;

  // Expands one byte-enable bit into that byte's bit-level write mask.
  function automatic logic [BYTE_WIDTH-1:0] strobe_to_mask(input logic strobe);
    return {BYTE_WIDTH{strobe}};
  endfunction

endpackage

// File: rtl/rggen_address_decoder.sv
// Combinational word-address decoder: byte address -> one-hot register hit plus miss flag.
// Address bits below the word offset do not take part in the decode.
module rggen_address_decoder
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int REGISTERS     = 4
) (
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  output logic [REGISTERS-1:0]     o_hit,
  output logic                     o_miss
);

  localparam int ADDR_LSB    = $clog2(DATA_WIDTH / BYTE_WIDTH);
  localparam int INDEX_WIDTH = ADDRESS_WIDTH - ADDR_LSB;

  logic [INDEX_WIDTH-1:0] w_index;

  assign w_index = i_address[ADDRESS_WIDTH-1:ADDR_LSB];

  for (genvar g = 0; g < REGISTERS; g++) begin : g_hit
    assign o_hit[g] = (w_index == INDEX_WIDTH'(g));
  end

  // Any index at or beyond REGISTERS matches no slot.
  assign o_miss = ~|o_hit;

endmodule

// File: rtl/rggen_register_access_ctrl.sv
// Host-side access controller for rggen bit fields: one outstanding access, IDLE -> ACCESS -> RESPONSE.
// Optional macro RGGEN_ACCESS_CTRL_ERROR_EN reports unmapped accesses on o_response_error.
module rggen_register_access_ctrl
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int REGISTERS     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_request_valid,
  output logic                            o_request_ready,
  input  logic [ADDRESS_WIDTH-1:0]        i_request_address,
  input  logic                            i_request_write,
  input  logic [DATA_WIDTH-1:0]           i_request_write_data,
  input  logic [DATA_WIDTH/8-1:0]         i_request_strobe,
  output logic                            o_response_valid,
  input  logic                            i_response_ready,
  output logic [DATA_WIDTH-1:0]           o_response_read_data,
  output logic                            o_response_error,
  output logic [REGISTERS-1:0]            o_write_access,
  output logic [REGISTERS-1:0]            o_read_access,
  output logic [DATA_WIDTH-1:0]           o_write_data,
  output logic [DATA_WIDTH-1:0]           o_write_mask,
  input  logic [REGISTERS*DATA_WIDTH-1:0] i_read_data
);

  localparam int STROBE_WIDTH = DATA_WIDTH / BYTE_WIDTH;

  access_state_e r_state;
  access_state_e w_next_state;

  logic [ADDRESS_WIDTH-1:0] r_address;
  logic                     r_write;
  logic [DATA_WIDTH-1:0]    r_write_data;
  logic [STROBE_WIDTH-1:0]  r_strobe;
  logic [DATA_WIDTH-1:0]    r_read_data;

  logic [REGISTERS-1:0]     w_hit;
  logic                     w_miss;
  logic [DATA_WIDTH-1:0]    w_mask;
  logic [DATA_WIDTH-1:0]    w_selected_data;
  logic                     w_request_handshake;

  rggen_address_decoder #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .REGISTERS     (REGISTERS)
  ) u_address_decoder (
    .i_address (r_address),
    .o_hit     (w_hit),
    .o_miss    (w_miss)
  );

  for (genvar g = 0; g < STROBE_WIDTH; g++) begin : g_mask
    assign w_mask[g*BYTE_WIDTH +: BYTE_WIDTH] = strobe_to_mask(r_strobe[g]);
  end

  always_comb begin
    w_selected_data = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (w_hit[i]) begin
        w_selected_data = w_selected_data | i_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_request_handshake = i_request_valid && o_request_ready;

  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Strobes decode straight from the state register, so an asynchronous reset clears them at once.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    w_next_state     = r_state;
    o_request_ready  = 1'b0;
    o_response_valid = 1'b0;
    o_write_access   = '0;
    o_read_access    = '0;
    o_write_mask     = '0;
    case (r_state)
      IDLE: begin
        o_request_ready = 1'b1;
        if (i_request_valid) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        o_write_access = r_write ? w_hit : '0;
        o_read_access  = r_write ? '0 : w_hit;
        o_write_mask   = w_mask;
        w_next_state   = RESPONSE;
      end
      RESPONSE: begin
        o_response_valid = 1'b1;
        if (i_response_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the captured request is reset as well, so o_write_data reads 0 until the first access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_address    <= '0;
      r_write      <= 1'b0;
      r_write_data <= '0;
      r_strobe     <= '0;
      r_read_data  <= '0;
    end else begin
      if (w_request_handshake) begin
        r_address    <= i_request_address;
        r_write      <= i_request_write;
        r_write_data <= i_request_write_data;
        r_strobe     <= i_request_strobe;
      end
      if (r_state == ACCESS) begin
        r_read_data <= (!r_write && !w_miss) ? w_selected_data : '0;
      end
    end
  end

`ifdef RGGEN_ACCESS_CTRL_ERROR_EN
  logic r_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_error <= w_miss;
    end
  end

  assign o_response_error = r_error;
`else
  assign o_response_error = 1'b0;
`endif

  assign o_write_data         = r_write_data;
  assign o_response_read_data = r_read_data;

endmodule

// File: tb/tb_rggen_register_access_ctrl.sv
// Directed bench for rggen_register_access_ctrl with default parameters.
// Expected error flag follows RGGEN_ACCESS_CTRL_ERROR_EN when the bench is built with it.
module tb_rggen_register_access_ctrl;

  logic         clk;
  logic         rst_n;
  logic         i_request_valid;
  logic         o_request_ready;
  logic [7:0]   i_request_address;
  logic         i_request_write;
  logic [31:0]  i_request_write_data;
  logic [3:0]   i_request_strobe;
  logic         o_response_valid;
  logic         i_response_ready;
  logic [31:0]  o_response_read_data;
  logic         o_response_error;
  logic [3:0]   o_write_access;
  logic [3:0]   o_read_access;
  logic [31:0]  o_write_data;
  logic [31:0]  o_write_mask;
  logic [127:0] i_read_data;

  int total = 0;
  int bad   = 0;

`ifdef RGGEN_ACCESS_CTRL_ERROR_EN
  localparam logic UNMAPPED_ERR = 1'b1;
`else
  localparam logic UNMAPPED_ERR = 1'b0;
`endif

  rggen_register_access_ctrl #(
    .ADDRESS_WIDTH (8),
    .DATA_WIDTH    (32),
    .REGISTERS     (4)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_request_valid      (i_request_valid),
    .o_request_ready      (o_request_ready),
    .i_request_address    (i_request_address),
    .i_request_write      (i_request_write),
    .i_request_write_data (i_request_write_data),
    .i_request_strobe     (i_request_strobe),
    .o_response_valid     (o_response_valid),
    .i_response_ready     (i_response_ready),
    .o_response_read_data (o_response_read_data),
    .o_response_error     (o_response_error),
    .o_write_access       (o_write_access),
    .o_read_access        (o_read_access),
    .o_write_data         (o_write_data),
    .o_write_mask         (o_write_mask),
    .i_read_data          (i_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request/response transaction with checks in every phase.
  task automatic access(input string tag, input logic [7:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strobe,
                        input logic [3:0] exp_wa, input logic [3:0] exp_ra,
                        input logic [31:0] exp_mask, input logic [31:0] exp_rdata,
                        input logic exp_err);
    check({tag, ".idle_ready"}, 32'(o_request_ready), 32'd1);
    i_request_valid      = 1'b1;
    i_request_address    = addr;
    i_request_write      = wr;
    i_request_write_data = wdata;
    i_request_strobe     = strobe;
    tick();
    i_request_valid = 1'b0;
    check({tag, ".acc_wa"},    32'(o_write_access), 32'(exp_wa));
    check({tag, ".acc_ra"},    32'(o_read_access), 32'(exp_ra));
    check({tag, ".acc_mask"},  o_write_mask, exp_mask);
    check({tag, ".acc_wdata"}, o_write_data, wdata);
    check({tag, ".acc_ready"}, 32'(o_request_ready), 32'd0);
    check({tag, ".acc_rvld"},  32'(o_response_valid), 32'd0);
    tick();
    check({tag, ".rsp_wa"},    32'(o_write_access), 32'd0);
    check({tag, ".rsp_ra"},    32'(o_read_access), 32'd0);
    check({tag, ".rsp_mask"},  o_write_mask, 32'd0);
    check({tag, ".rsp_rvld"},  32'(o_response_valid), 32'd1);
    check({tag, ".rsp_rdata"}, o_response_read_data, exp_rdata);
    check({tag, ".rsp_err"},   32'(o_response_error), 32'(exp_err));
    check({tag, ".rsp_wdata"}, o_write_data, wdata);
    i_response_ready = 1'b1;
    tick();
    i_response_ready = 1'b0;
    check({tag, ".done_rvld"},  32'(o_response_valid), 32'd0);
    check({tag, ".done_ready"}, 32'(o_request_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held_data;

    rst_n                = 1'b0;
    i_request_valid      = 1'b0;
    i_request_address    = '0;
    i_request_write      = 1'b0;
    i_request_write_data = '0;
    i_request_strobe     = '0;
    i_response_ready     = 1'b0;
    i_read_data          = {32'h12345678, 32'h33333333, 32'h22222222, 32'hA5A50001};

    #12;
    check("rst.req_ready", 32'(o_request_ready), 32'd1);
    check("rst.rsp_valid", 32'(o_response_valid), 32'd0);
    check("rst.rdata",     o_response_read_data, 32'd0);
    check("rst.err",       32'(o_response_error), 32'd0);
    check("rst.wa",        32'(o_write_access), 32'd0);
    check("rst.ra",        32'(o_read_access), 32'd0);
    check("rst.wdata",     o_write_data, 32'd0);
    check("rst.mask",      o_write_mask, 32'd0);
    rst_n = 1'b1;
    tick();

    access("wr04", 8'h04, 1'b1, 32'hDEADBEEF, 4'hF, 4'b0010, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0);
    access("wr08_s5", 8'h08, 1'b1, 32'hCAFEF00D, 4'h5, 4'b0100, 4'b0000, 32'h00FF00FF, 32'h0, 1'b0);
    access("wr08_s0", 8'h08, 1'b1, 32'h01020304, 4'h0, 4'b0100, 4'b0000, 32'h00000000, 32'h0, 1'b0);
    access("wr00_sA", 8'h00, 1'b1, 32'h55AA55AA, 4'hA, 4'b0001, 4'b0000, 32'hFF00FF00, 32'h0, 1'b0);
    access("rd0D", 8'h0D, 1'b0, 32'h0, 4'h0, 4'b0000, 4'b1000, 32'h0, 32'h12345678, 1'b0);
    access("rd06", 8'h06, 1'b0, 32'h0, 4'h0, 4'b0000, 4'b0010, 32'h0, 32'h22222222, 1'b0);
    access("rd10_unmapped", 8'h10, 1'b0, 32'h0, 4'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, UNMAPPED_ERR);
    access("wrFC_unmapped", 8'hFC, 1'b1, 32'h77777777, 4'hF, 4'b0000, 4'b0000, 32'hFFFFFFFF, 32'h0, UNMAPPED_ERR);
    access("rd0C_after_err", 8'h0C, 1'b0, 32'h0, 4'h0, 4'b0000, 4'b1000, 32'h0, 32'h12345678, 1'b0);

    // Back-pressure: response held while a second request waits.
    i_request_valid   = 1'b1;
    i_request_address = 8'h00;
    i_request_write   = 1'b0;
    tick();
    i_request_address    = 8'h04;
    i_request_write      = 1'b1;
    i_request_write_data = 32'h0BADC0DE;
    i_request_strobe     = 4'h3;
    check("bp.acc_ra", 32'(o_read_access), 32'b0001);
    tick();
    i_read_data[31:0] = 32'hFFFF0000;
    held_data = 32'hA5A50001;
    for (int c = 0; c < 5; c++) begin
      check("bp.rvld",  32'(o_response_valid), 32'd1);
      check("bp.rdata", o_response_read_data, held_data);
      check("bp.ready", 32'(o_request_ready), 32'd0);
      check("bp.wa",    32'(o_write_access), 32'd0);
      tick();
    end
    check("bp.wdata_not_taken", o_write_data, 32'h0);
    i_response_ready = 1'b1;
    tick();
    i_response_ready = 1'b0;
    check("bp.idle_rvld",  32'(o_response_valid), 32'd0);
    check("bp.idle_ready", 32'(o_request_ready), 32'd1);
    tick();
    i_request_valid = 1'b0;
    check("bp.second_wa",   32'(o_write_access), 32'b0010);
    check("bp.second_mask", o_write_mask, 32'h0000FFFF);
    check("bp.second_data", o_write_data, 32'h0BADC0DE);
    tick();
    check("bp.second_rvld", 32'(o_response_valid), 32'd1);
    i_response_ready = 1'b1;
    tick();
    i_response_ready = 1'b0;

    // Reset asserted while in ACCESS.
    i_request_valid      = 1'b1;
    i_request_address    = 8'h0C;
    i_request_write      = 1'b1;
    i_request_write_data = 32'h13572468;
    i_request_strobe     = 4'hF;
    tick();
    i_request_valid = 1'b0;
    check("rstmid.acc_wa", 32'(o_write_access), 32'b1000);
    rst_n = 1'b0;
    #1;
    check("rstmid.wa",    32'(o_write_access), 32'd0);
    check("rstmid.mask",  o_write_mask, 32'd0);
    check("rstmid.ready", 32'(o_request_ready), 32'd1);
    check("rstmid.rvld",  32'(o_response_valid), 32'd0);
    tick();
    check("rstmid.held_wa", 32'(o_write_access), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rstmid.post_ready", 32'(o_request_ready), 32'd1);
    check("rstmid.post_rvld",  32'(o_response_valid), 32'd0);
    check("rstmid.post_wa",    32'(o_write_access), 32'd0);
    tick();
    check("rstmid.post2_rvld", 32'(o_response_valid), 32'd0);

    access("post_rst_rd", 8'h08, 1'b0, 32'h0, 4'h0, 4'b0000, 4'b0100, 32'h0, 32'h33333333, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
